// File: rtl/ping_pong_pkg.sv
// Shared ping-pong counter definitions: FSM states, direction encoding and
// the single reference model of one counter step, reused by checkers and by
// future counter variants.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } pp_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter the model supports; narrower counters are zero-extended
  // on the way in and masked back to their own width on the way out.
  localparam int unsigned PP_MAX_W = 32;

  typedef logic [PP_MAX_W-1:0] pp_val_t;

  typedef struct packed {
    pp_val_t out;
    logic    dir;
    logic    is_bounce;
    logic    is_flip;
  } pp_next_t;

  // One step of the counter: given the current value/direction and the
  // controls applied with it, return the value/direction one clock later.
  function automatic pp_next_t pp_next(
    input pp_val_t     cur_out,
    input logic        cur_dir,
    input logic        enable,
    input logic        flip,
    input pp_val_t     max_v,
    input pp_val_t     min_v,
    input logic        rst_n,
    input int unsigned width
  );
    pp_next_t res;
    pp_val_t  mask;
    logic     nd;
    res.out       = cur_out;
    res.dir       = cur_dir;
    res.is_bounce = 1'b0;
    res.is_flip   = 1'b0;
    nd            = cur_dir;
    if (width >= PP_MAX_W) begin
      mask = '1;
    end else begin
      mask = (pp_val_t'(1) << width) - pp_val_t'(1);
    end
    if (!rst_n) begin
      res.out = min_v;
      res.dir = DIR_UP;
    end else if (!enable || (max_v <= min_v) || (cur_out > max_v) || (cur_out < min_v)) begin
      // Disabled, empty range or value outside the range: the counter holds.
      res.out = cur_out;
      res.dir = cur_dir;
    end else begin
      if (flip) begin
        nd = ~cur_dir;
      end else if (cur_out == min_v) begin
        nd = DIR_UP;
      end else if (cur_out == max_v) begin
        nd = DIR_DN;
      end else begin
        nd = cur_dir;
      end
      // Wraps within the counter width (a flip at the top of the code space).
      if (nd) begin
        res.out = (cur_out + pp_val_t'(1)) & mask;
      end else begin
        res.out = (cur_out - pp_val_t'(1)) & mask;
      end
      res.dir       = nd;
      res.is_flip   = flip;
      res.is_bounce = !flip && ((cur_out == min_v) || (cur_out == max_v)) && (nd != cur_dir);
    end
    return res;
  endfunction

endpackage

// File: rtl/ping_pong_model.sv
// Combinational wrapper around the shared ping-pong step model, sized to the
// counter width and exposing bounce/flip strobes for statistics.
module ping_pong_model
  import ping_pong_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] out_i,
  input  logic             dir_i,
  input  logic             enable_i,
  input  logic             flip_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic             dut_rst_n_i,
  output logic [WIDTH-1:0] nxt_out_o,
  output logic             nxt_dir_o,
  output logic             is_bounce_o,
  output logic             is_flip_o
);

  pp_next_t res_s;
  logic     unused_hi_s;

  // Evaluate the reference step on the zero-extended sample.
  always_comb begin
    res_s = pp_next(pp_val_t'(out_i), dir_i, enable_i, flip_i,
                    pp_val_t'(max_i), pp_val_t'(min_i), dut_rst_n_i, WIDTH);
  end

  assign nxt_out_o   = res_s.out[WIDTH-1:0];
  assign nxt_dir_o   = res_s.dir;
  assign is_bounce_o = res_s.is_bounce;
  assign is_flip_o   = res_s.is_flip;
  // Bits above WIDTH are always zero after masking; fold them away.
  assign unused_hi_s = ^res_s.out;

endmodule

// File: rtl/ping_pong_sequence_checker.sv
// Receive-side monitor for the ping-pong counter: predicts each next sample,
// flags mismatches with a registered one-cycle pulse, keeps saturating
// error/bounce/flip statistics and raises a sticky fault at a threshold.
module ping_pong_sequence_checker
  import ping_pong_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             obs_valid,
  input  logic             dut_rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] obs_out,
  input  logic             obs_dir,
  output logic             locked,
  output logic             mismatch,
  output logic             fault,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bounce_count,
  output logic [CNT_W-1:0] flip_count
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(FAULT_THRESH);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  pp_state_e        state_q, state_d;
  logic [WIDTH-1:0] pred_out_q, pred_out_d;
  logic             pred_dir_q, pred_dir_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bounce_q, bounce_d;
  logic [CNT_W-1:0] flip_q, flip_d;

  logic [WIDTH-1:0] nxt_out_s;
  logic             nxt_dir_s;
  logic             is_bounce_s;
  logic             is_flip_s;
  logic             miss_s;

  ping_pong_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .out_i       (obs_out),
    .dir_i       (obs_dir),
    .enable_i    (enable),
    .flip_i      (flip),
    .max_i       (max),
    .min_i       (min),
    .dut_rst_n_i (dut_rst_n),
    .nxt_out_o   (nxt_out_s),
    .nxt_dir_o   (nxt_dir_s),
    .is_bounce_o (is_bounce_s),
    .is_flip_o   (is_flip_s)
  );

  // Current sample against the prediction made from the previous sample.
  assign miss_s = (obs_out != pred_out_q) || (obs_dir != pred_dir_q);

  // Next-state logic: clear first, then advance only on valid samples.
  always_comb begin
    state_d    = state_q;
    pred_out_d = pred_out_q;
    pred_dir_d = pred_dir_q;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    fault_d    = fault_q;
    err_d      = err_q;
    bounce_d   = bounce_q;
    flip_d     = flip_q;
    if (clr) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      fault_d  = 1'b0;
      err_d    = '0;
      bounce_d = '0;
      flip_d   = '0;
    end else if (obs_valid) begin
      // Prediction always follows the observed sample, so a single bad
      // value resynchronises instead of producing a cascade of errors.
      pred_out_d = nxt_out_s;
      pred_dir_d = nxt_dir_s;
      case (state_q)
        IDLE: begin
          state_d  = LOCK;
          locked_d = 1'b1;
        end
        LOCK, FAULT: begin
          locked_d = 1'b1;
          if (miss_s) begin
            mismatch_d = 1'b1;
            err_d      = sat_inc(err_q);
          end else begin
            err_d      = err_q;
          end
          if (is_flip_s) begin
            flip_d = sat_inc(flip_q);
          end else begin
            flip_d = flip_q;
          end
          if (is_bounce_s) begin
            bounce_d = sat_inc(bounce_q);
          end else begin
            bounce_d = bounce_q;
          end
          if ((state_q == LOCK) && (err_d == CNT_THRESH)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pred_out_q <= '0;
      pred_dir_q <= DIR_UP;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      fault_q    <= 1'b0;
      err_q      <= '0;
      bounce_q   <= '0;
      flip_q     <= '0;
    end else begin
      state_q    <= state_d;
      pred_out_q <= pred_out_d;
      pred_dir_q <= pred_dir_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      fault_q    <= fault_d;
      err_q      <= err_d;
      bounce_q   <= bounce_d;
      flip_q     <= flip_d;
    end
  end

  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign fault        = fault_q;
  assign err_count    = err_q;
  assign bounce_count = bounce_q;
  assign flip_count   = flip_q;

endmodule

// File: tb/tb_ping_pong_sequence_checker.sv
// Directed bench for the ping-pong sequence checker: main instance with the
// default widths plus a CNT_W=2 instance on the same stimulus for saturation.
module tb_ping_pong_sequence_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       obs_valid = 1'b0;
  logic       dut_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flip = 1'b0;
  logic [3:0] max = 4'd0;
  logic [3:0] min = 4'd0;
  logic [3:0] obs_out = 4'd0;
  logic       obs_dir = 1'b0;

  logic       locked, mismatch, fault;
  logic [7:0] err_count, bounce_count, flip_count;
  logic       locked2, mismatch2, fault2;
  logic [1:0] err_count2, bounce_count2, flip_count2;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] t1_out [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3};
  logic       t1_dir [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] t4_out [4] = '{4'd9, 4'd8, 4'd7, 4'd6};
  logic [3:0] t6_out [5] = '{4'd3, 4'd2, 4'd3, 4'd2, 4'd3};
  logic       t6_dir [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  ping_pong_sequence_checker #(.WIDTH(4), .CNT_W(8), .FAULT_THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .obs_valid(obs_valid),
    .dut_rst_n(dut_rst_n), .enable(enable), .flip(flip), .max(max), .min(min),
    .obs_out(obs_out), .obs_dir(obs_dir), .locked(locked), .mismatch(mismatch),
    .fault(fault), .err_count(err_count), .bounce_count(bounce_count),
    .flip_count(flip_count)
  );

  ping_pong_sequence_checker #(.WIDTH(4), .CNT_W(2), .FAULT_THRESH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .obs_valid(obs_valid),
    .dut_rst_n(dut_rst_n), .enable(enable), .flip(flip), .max(max), .min(min),
    .obs_out(obs_out), .obs_dir(obs_dir), .locked(locked2), .mismatch(mismatch2),
    .fault(fault2), .err_count(err_count2), .bounce_count(bounce_count2),
    .flip_count(flip_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic dr, input logic en, input logic fl,
                      input logic [3:0] mx, input logic [3:0] mn,
                      input logic [3:0] o, input logic d);
    obs_valid = v;
    dut_rst_n = dr;
    enable    = en;
    flip      = fl;
    max       = mx;
    min       = mn;
    obs_out   = o;
    obs_dir   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_bounce", 32'(bounce_count), 32'd0);
    chk("rst_flip", 32'(flip_count), 32'd0);
    rst_n = 1'b1;

    // 1: lock while the counter is in reset, then a clean up/down run
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd2, 4'd0, 1'b1);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_lock_mm", 32'(mismatch), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, t1_out[i], t1_dir[i]);
      chk("t1_run_mm", 32'(mismatch), 32'd0);
    end
    chk("t1_bounce", 32'(bounce_count), 32'd2);
    chk("t1_err", 32'(err_count), 32'd0);

    // 2: flip at 4 going up -> 3 going down
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd2, 4'd4, 1'b1);
    chk("t2_flip", 32'(flip_count), 32'd1);
    chk("t2_bounce", 32'(bounce_count), 32'd2);
    chk("t2_mm", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd3, 1'b0);
    chk("t2_after_mm", 32'(mismatch), 32'd0);

    // 3: single injected error, then resync from the bad value
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd2, 1'b0);
    chk("t3_bounce", 32'(bounce_count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd7, 1'b1);
    chk("t3_mm_pulse", 32'(mismatch), 32'd1);
    chk("t3_err", 32'(err_count), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd7, 1'b1);
    chk("t3_mm_clear", 32'(mismatch), 32'd0);
    chk("t3_err_hold", 32'(err_count), 32'd1);
    chk("t3_bounce_hold", 32'(bounce_count), 32'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd2, 4'd7, 1'b1);
    chk("t3_drst_mm", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd2, 1'b1);
    chk("t3_post_drst_mm", 32'(mismatch), 32'd0);

    // 5: empty/inverted range and enable=0 hold; obs_valid gaps freeze state
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 1'b1);
    chk("t5_eq_mm", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 4'd3, 1'b1);
    chk("t5_inv_mm", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd2, 4'd3, 1'b1);
    chk("t5_inv_hold_mm", 32'(mismatch), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd3, 1'b1);
    chk("t5_en0_hold_mm", 32'(mismatch), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd2, 4'd0, 1'b0);
    end
    chk("t5_gap_locked", 32'(locked), 32'd1);
    chk("t5_gap_mm", 32'(mismatch), 32'd0);
    chk("t5_gap_err", 32'(err_count), 32'd1);
    chk("t5_gap_flip", 32'(flip_count), 32'd1);
    chk("t5_gap_bounce", 32'(bounce_count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd4, 1'b1);
    chk("t5_resume_mm", 32'(mismatch), 32'd0);

    // 4: clr beats a same-cycle mismatch, relock, four errors to fault
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd9, 1'b0);
    clr = 1'b0;
    chk("t4_clr_mm", 32'(mismatch), 32'd0);
    chk("t4_clr_err", 32'(err_count), 32'd0);
    chk("t4_clr_locked", 32'(locked), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd4, 1'b1);
    chk("t4_relock", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, t4_out[i], 1'b1);
      chk("t4_err_mm", 32'(mismatch), 32'd1);
      chk("t4_err_cnt", 32'(err_count), 32'(i + 1));
      chk("t4_fault", 32'(fault), (i == 3) ? 32'd1 : 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd6, 1'b1);
    chk("t4_fault_ok_mm", 32'(mismatch), 32'd0);
    chk("t4_fault_sticky", 32'(fault), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd0, 1'b0);
    chk("t4_fault_cmp", 32'(err_count), 32'd5);
    clr = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd2, 4'd0, 1'b0);
    clr = 1'b0;
    chk("t4_clr2_err", 32'(err_count), 32'd0);
    chk("t4_clr2_fault", 32'(fault), 32'd0);
    chk("t4_clr2_locked", 32'(locked), 32'd0);

    // 6: tight range 2..3 bounces every sample; CNT_W=2 copy saturates
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd2, 1'b1);
    chk("t6_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, t6_out[i], t6_dir[i]);
      chk("t6_mm", 32'(mismatch), 32'd0);
    end
    chk("t6_bounce", 32'(bounce_count), 32'd5);
    chk("t6_bounce_sat", 32'(bounce_count2), 32'd3);

    // Asynchronous reset mid-LOCK, checked before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_bounce", 32'(bounce_count), 32'd0);
    chk("arst_bounce2", 32'(bounce_count2), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
